// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential accumulator ALU: opcodes, FSM states, helpers.
package alu_seq_pkg;

    localparam int OPW = 4;

    localparam logic [OPW-1:0] OP_ADD = 4'd0;
    localparam logic [OPW-1:0] OP_SUB = 4'd1;
    localparam logic [OPW-1:0] OP_NAND = 4'd2;
    localparam logic [OPW-1:0] OP_ADC = 4'd3;
    localparam logic [OPW-1:0] OP_SBC = 4'd4;
    localparam logic [OPW-1:0] OP_SHL = 4'd5;
    localparam logic [OPW-1:0] OP_SHR = 4'd6;
    localparam logic [OPW-1:0] OP_ROL = 4'd7;
    localparam logic [OPW-1:0] OP_ROR = 4'd8;
    localparam logic [OPW-1:0] OP_MUL = 4'd9;
    localparam logic [OPW-1:0] OP_NOP = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_MUL   = 2'd2
    } state_e;

    // True for the four opcodes that move bits one position per cycle.
    function automatic logic is_shift_op(input logic [OPW-1:0] op);
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) || (op == OP_ROR);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Control/status bundle between the control unit (master) and the ALU (slave).
interface alu_seq_if
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) ();
    logic [OPW-1:0]   op;
    logic [SHW-1:0]   shamt;
    logic             ld_acc;
    logic             start;
    logic             dbus_select;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] latch;
    logic             c;
    logic             z;
    logic             v;
    logic             busy;
    logic             done;

    modport master (
        output op, shamt, ld_acc, start, dbus_select,
        input  acc, latch, c, z, v, busy, done
    );

    modport slave (
        input  op, shamt, ld_acc, start, dbus_select,
        output acc, latch, c, z, v, busy, done
    );
endinterface

// File: rtl/alu_seq_addsub.sv
// Combinational WIDTH-bit adder/subtractor with carry-in, carry-out and signed overflow.
module alu_seq_addsub #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);
    logic [WIDTH-1:0] b_eff_s;
    logic [WIDTH:0]   full_s;

    // Subtraction is A + ~B + cin; overflow when both addends share a sign the sum lacks.
    always_comb begin
        b_eff_s = sub_i ? ~b_i : b_i;
        full_s  = {1'b0, a_i} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, cin_i};
        sum_o   = full_s[WIDTH-1:0];
        cout_o  = full_s[WIDTH];
        ovf_o   = (a_i[WIDTH-1] == b_eff_s[WIDTH-1]) && (full_s[WIDTH-1] != a_i[WIDTH-1]);
    end
endmodule

// File: rtl/alu_seq.sv
// Sequential accumulator ALU: single-cycle arithmetic/logic, multi-cycle shifts and multiply.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    alu_seq_if.slave         bus,
    inout  wire  [WIDTH-1:0] d_bus
);
    localparam int CW = SHW + 1;   // counter must reach WIDTH for multiply
    localparam int PW = 2 * WIDTH;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d, latch_q, latch_d;
    logic [PW-1:0]    prod_q, prod_d;
    logic             c_q, c_d, z_q, z_d, v_q, v_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [OPW-1:0]   sop_q, sop_d;

    logic [WIDTH-1:0] as_a_s, as_b_s, as_sum_s;
    logic             as_cin_s, as_sub_s, as_cout_s, as_ovf_s;
    logic [WIDTH-1:0] shifted_s;
    logic             shout_s;
    logic [PW-1:0]    mul_next_s;

    alu_seq_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a_i    (as_a_s),
        .b_i    (as_b_s),
        .cin_i  (as_cin_s),
        .sub_i  (as_sub_s),
        .sum_o  (as_sum_s),
        .cout_o (as_cout_s),
        .ovf_o  (as_ovf_s)
    );

    // Adder operands: partial-product accumulate during MUL, acc op d_bus otherwise.
    always_comb begin
        as_a_s   = acc_q;
        as_b_s   = d_bus;
        as_cin_s = 1'b0;
        as_sub_s = 1'b0;
        if (state_q == S_MUL) begin
            as_a_s = prod_q[PW-1:WIDTH];
            as_b_s = latch_q;
        end else begin
            case (bus.op)
                OP_SUB:  begin as_sub_s = 1'b1; as_cin_s = 1'b1; end
                OP_ADC:  begin as_cin_s = c_q; end
                OP_SBC:  begin as_sub_s = 1'b1; as_cin_s = c_q; end
                default: begin as_sub_s = 1'b0; as_cin_s = 1'b0; end
            endcase
        end
    end

    // One-position shift/rotate of acc for the op captured at start, plus the bit moved out.
    always_comb begin
        shifted_s = acc_q;
        shout_s   = 1'b0;
        case (sop_q)
            OP_SHL:  begin shifted_s = {acc_q[WIDTH-2:0], 1'b0};         shout_s = acc_q[WIDTH-1]; end
            OP_SHR:  begin shifted_s = {1'b0, acc_q[WIDTH-1:1]};         shout_s = acc_q[0]; end
            OP_ROL:  begin shifted_s = {acc_q[WIDTH-2:0], acc_q[WIDTH-1]}; shout_s = acc_q[WIDTH-1]; end
            OP_ROR:  begin shifted_s = {acc_q[0], acc_q[WIDTH-1:1]};     shout_s = acc_q[0]; end
            default: begin shifted_s = acc_q;                            shout_s = 1'b0; end
        endcase
    end

    // Shift-add multiply step: add multiplicand into the upper half when the LSB is set, then shift right.
    always_comb begin
        if (prod_q[0]) begin
            mul_next_s = {as_cout_s, as_sum_s, prod_q[WIDTH-1:1]};
        end else begin
            mul_next_s = {1'b0, prod_q[PW-1:1]};
        end
    end

    // Next-state and datapath updates; undriven/unknown strobes fall into the hold branches.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        latch_d = latch_q;
        prod_d  = prod_q;
        c_d     = c_q;
        z_d     = z_q;
        v_d     = v_q;
        cnt_d   = cnt_q;
        sop_d   = sop_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.ld_acc == 1'b1) begin
                    acc_d = d_bus;
                end else if (bus.start == 1'b1) begin
                    latch_d = d_bus;
                    if (is_shift_op(bus.op)) begin
                        if (bus.shamt == {SHW{1'b0}}) begin
                            z_d    = (acc_q == {WIDTH{1'b0}});
                            v_d    = 1'b0;
                            done_d = 1'b1;
                        end else begin
                            sop_d   = bus.op;
                            cnt_d   = {1'b0, bus.shamt};
                            state_d = S_SHIFT;
                        end
                    end else begin
                        case (bus.op)
                            OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
                                acc_d  = as_sum_s;
                                c_d    = as_cout_s;
                                v_d    = as_ovf_s;
                                z_d    = (as_sum_s == {WIDTH{1'b0}});
                                done_d = 1'b1;
                            end
                            OP_NAND: begin
                                acc_d  = ~(acc_q & d_bus);
                                v_d    = 1'b0;
                                z_d    = ((acc_q & d_bus) == {WIDTH{1'b1}});
                                done_d = 1'b1;
                            end
                            OP_MUL: begin
                                prod_d  = {{WIDTH{1'b0}}, acc_q};
                                cnt_d   = CW'(WIDTH);
                                state_d = S_MUL;
                            end
                            default: begin
                                done_d = 1'b1;
                            end
                        endcase
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                acc_d = shifted_s;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    c_d     = shout_s;
                    z_d     = (shifted_s == {WIDTH{1'b0}});
                    v_d     = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_MUL: begin
                prod_d = mul_next_s;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    acc_d   = mul_next_s[WIDTH-1:0];
                    c_d     = (mul_next_s[PW-1:WIDTH] != {WIDTH{1'b0}});
                    z_d     = (mul_next_s[WIDTH-1:0] == {WIDTH{1'b0}});
                    v_d     = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_MUL;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State register with synchronous reset; reset aborts any operation without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            acc_q   <= {WIDTH{1'b0}};
            latch_q <= {WIDTH{1'b0}};
            prod_q  <= {PW{1'b0}};
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            v_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= {CW{1'b0}};
            sop_q   <= OP_NOP;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            latch_q <= latch_d;
            prod_q  <= prod_d;
            c_q     <= c_d;
            z_q     <= z_d;
            v_q     <= v_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            sop_q   <= sop_d;
        end
    end

    assign bus.acc   = acc_q;
    assign bus.latch = latch_q;
    assign bus.c     = c_q;
    assign bus.z     = z_q;
    assign bus.v     = v_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

    // acc goes onto the shared bus only when selected and no multi-cycle op is running.
    assign d_bus = ((bus.dbus_select == 1'b1) && !busy_q) ? acc_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=8.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] tb_bus = 8'h00;
    logic       tb_oe = 1'b0;
    wire  [7:0] d_bus;
    int         n_checks = 0;
    int         n_errors = 0;
    int         lat, bcyc;
    logic       seen_done;

    alu_seq_if #(.WIDTH(8), .SHW(3)) bus_if ();

    alu_seq #(.WIDTH(8), .SHW(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave),
        .d_bus (d_bus)
    );

    assign d_bus = tb_oe ? tb_bus : 8'hzz;

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_acc(input logic [7:0] val);
        tb_bus = val; tb_oe = 1'b1; bus_if.ld_acc = 1'b1;
        @(posedge clk); #1;
        bus_if.ld_acc = 1'b0; tb_oe = 1'b0;
    endtask

    // Start op at E0, then count edges until done; poke>=0 fires start+ld_acc while busy.
    task automatic run_op(input logic [3:0] o, input logic [7:0] b, input logic [2:0] sh,
                          input int poke, output int lat_o, output int bcyc_o);
        bus_if.op = o; bus_if.shamt = sh; tb_bus = b; tb_oe = 1'b1; bus_if.start = 1'b1;
        @(posedge clk); #1;
        bus_if.start = 1'b0; tb_oe = 1'b0;
        lat_o = 0; bcyc_o = 0;
        while (bus_if.done !== 1'b1 && lat_o < 40) begin
            if (bus_if.busy === 1'b1) bcyc_o++;
            if (lat_o == poke) begin
                bus_if.start = 1'b1; bus_if.ld_acc = 1'b1; bus_if.op = OP_ADD;
                tb_bus = 8'h55; tb_oe = 1'b1;
            end
            @(posedge clk); #1;
            bus_if.start = 1'b0; bus_if.ld_acc = 1'b0; tb_oe = 1'b0;
            lat_o++;
        end
        check_eq("done_seen", {15'd0, bus_if.done}, 16'd1);
    endtask

    initial begin
        bus_if.op = OP_NOP; bus_if.shamt = 3'd0; bus_if.ld_acc = 1'b0;
        bus_if.start = 1'b0; bus_if.dbus_select = 1'b0;

        // 1: reset values, then ADD
        reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
        check_eq("rst_acc", {8'd0, bus_if.acc}, 16'h0000);
        check_eq("rst_latch", {8'd0, bus_if.latch}, 16'h0000);
        check_eq("rst_flags", {13'd0, bus_if.c, bus_if.z, bus_if.v}, 16'h0000);
        check_eq("rst_busy_done", {14'd0, bus_if.busy, bus_if.done}, 16'h0000);
        load_acc(8'h9E);
        check_eq("ld_acc", {8'd0, bus_if.acc}, 16'h009E);
        check_eq("ld_nodone", {15'd0, bus_if.done}, 16'd0);
        run_op(OP_ADD, 8'h61, 3'd0, -1, lat, bcyc);
        check_eq("add_acc", {8'd0, bus_if.acc}, 16'h00FF);
        check_eq("add_czv", {13'd0, bus_if.c, bus_if.z, bus_if.v}, 16'h0000);
        check_eq("add_lat", 16'(lat), 16'd0);
        check_eq("add_busy", 16'(bcyc), 16'd0);
        @(posedge clk); #1;
        check_eq("add_done_pulse", {15'd0, bus_if.done}, 16'd0);

        // 2: SUB, SBC, ADD overflow, NAND
        load_acc(8'h61);
        run_op(OP_SUB, 8'h61, 3'd0, -1, lat, bcyc);
        check_eq("sub_acc", {8'd0, bus_if.acc}, 16'h0000);
        check_eq("sub_czv", {13'd0, bus_if.c, bus_if.z, bus_if.v}, 16'h0006);
        run_op(OP_SBC, 8'h01, 3'd0, -1, lat, bcyc);
        check_eq("sbc_acc", {8'd0, bus_if.acc}, 16'h00FF);
        check_eq("sbc_czv", {13'd0, bus_if.c, bus_if.z, bus_if.v}, 16'h0000);
        load_acc(8'h7F);
        run_op(OP_ADD, 8'h01, 3'd0, -1, lat, bcyc);
        check_eq("ovf_acc", {8'd0, bus_if.acc}, 16'h0080);
        check_eq("ovf_czv", {13'd0, bus_if.c, bus_if.z, bus_if.v}, 16'h0001);
        run_op(OP_NAND, 8'hFF, 3'd0, -1, lat, bcyc);
        check_eq("nand_acc", {8'd0, bus_if.acc}, 16'h007F);
        check_eq("nand_czv", {13'd0, bus_if.c, bus_if.z, bus_if.v}, 16'h0000);

        // 3: shifts and rotates
        load_acc(8'h01);
        run_op(OP_ROR, 8'h00, 3'd1, -1, lat, bcyc);
        check_eq("ror_acc", {8'd0, bus_if.acc}, 16'h0080);
        check_eq("ror_c", {15'd0, bus_if.c}, 16'd1);
        check_eq("ror_lat", 16'(lat), 16'd1);
        run_op(OP_SHL, 8'h00, 3'd0, -1, lat, bcyc);
        check_eq("shl0_acc", {8'd0, bus_if.acc}, 16'h0080);
        check_eq("shl0_czv", {13'd0, bus_if.c, bus_if.z, bus_if.v}, 16'h0004);
        check_eq("shl0_lat", 16'(lat), 16'd0);
        load_acc(8'h81);
        run_op(OP_SHL, 8'h00, 3'd3, -1, lat, bcyc);
        check_eq("shl3_acc", {8'd0, bus_if.acc}, 16'h0008);
        check_eq("shl3_c", {15'd0, bus_if.c}, 16'd0);
        check_eq("shl3_lat", 16'(lat), 16'd3);
        check_eq("shl3_busy", 16'(bcyc), 16'd3);

        // 4: multiply
        load_acc(8'h0D);
        run_op(OP_MUL, 8'h0B, 3'd0, -1, lat, bcyc);
        check_eq("mul_acc", {8'd0, bus_if.acc}, 16'h008F);
        check_eq("mul_czv", {13'd0, bus_if.c, bus_if.z, bus_if.v}, 16'h0000);
        check_eq("mul_lat", 16'(lat), 16'd8);
        check_eq("mul_busy", 16'(bcyc), 16'd8);
        check_eq("mul_latch", {8'd0, bus_if.latch}, 16'h000B);
        @(posedge clk); #1;
        check_eq("mul_done_pulse", {14'd0, bus_if.busy, bus_if.done}, 16'd0);
        load_acc(8'h10);
        run_op(OP_MUL, 8'h10, 3'd0, -1, lat, bcyc);
        check_eq("mul2_acc", {8'd0, bus_if.acc}, 16'h0000);
        check_eq("mul2_cz", {14'd0, bus_if.c, bus_if.z}, 16'h0003);

        // 5: reset mid-multiply, then ignored strobes while busy
        load_acc(8'h0D);
        bus_if.op = OP_MUL; tb_bus = 8'h0B; tb_oe = 1'b1; bus_if.start = 1'b1;
        @(posedge clk); #1;
        bus_if.start = 1'b0; tb_oe = 1'b0; seen_done = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus_if.done === 1'b1) seen_done = 1'b1;
        end
        reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
        check_eq("abort_acc", {8'd0, bus_if.acc}, 16'h0000);
        check_eq("abort_latch", {8'd0, bus_if.latch}, 16'h0000);
        check_eq("abort_flags", {11'd0, bus_if.c, bus_if.z, bus_if.v, bus_if.busy, bus_if.done}, 16'h0000);
        check_eq("abort_nodone", {15'd0, seen_done}, 16'd0);
        load_acc(8'h10);
        run_op(OP_ADD, 8'h22, 3'd0, -1, lat, bcyc);
        check_eq("post_abort_add", {8'd0, bus_if.acc}, 16'h0032);
        load_acc(8'h03);
        run_op(OP_MUL, 8'h05, 3'd0, 2, lat, bcyc);
        check_eq("ign_acc", {8'd0, bus_if.acc}, 16'h000F);
        check_eq("ign_latch", {8'd0, bus_if.latch}, 16'h0005);
        check_eq("ign_lat", 16'(lat), 16'd8);

        // 6: bus drive, ld_acc priority, unknown strobes
        load_acc(8'h5A);
        tb_bus = 8'h3C; tb_oe = 1'b1; bus_if.dbus_select = 1'b0; #1;
        check_eq("bus_not_sel", {8'd0, d_bus}, 16'h003C);
        tb_oe = 1'b0; bus_if.dbus_select = 1'b1; #1;
        check_eq("bus_drive_idle", {8'd0, d_bus}, 16'h005A);
        bus_if.op = OP_SHL; bus_if.shamt = 3'd3; bus_if.start = 1'b1;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        tb_bus = 8'h00; tb_oe = 1'b1; #1;
        check_eq("bus_busy_released", {8'd0, d_bus}, 16'h0000);
        check_eq("bus_busy_flag", {15'd0, bus_if.busy}, 16'd1);
        tb_oe = 1'b0;
        lat = 0;
        while (bus_if.done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check_eq("bus_shl_done", {15'd0, bus_if.done}, 16'd1);
        check_eq("bus_shl_acc", {8'd0, bus_if.acc}, 16'h00D0);
        check_eq("bus_shl_latch", {8'd0, bus_if.latch}, 16'h005A);
        #1;
        check_eq("bus_drive_after", {8'd0, d_bus}, 16'h00D0);
        bus_if.dbus_select = 1'b0;
        tb_bus = 8'h33; tb_oe = 1'b1; bus_if.op = OP_ADD; bus_if.ld_acc = 1'b1; bus_if.start = 1'b1;
        @(posedge clk); #1;
        bus_if.ld_acc = 1'b0; bus_if.start = 1'b0; tb_oe = 1'b0;
        check_eq("ld_wins_acc", {8'd0, bus_if.acc}, 16'h0033);
        check_eq("ld_wins_nodone", {15'd0, bus_if.done}, 16'd0);
        check_eq("ld_wins_latch", {8'd0, bus_if.latch}, 16'h005A);
        bus_if.op = OP_NOP; bus_if.start = 1'bx; bus_if.dbus_select = 1'bx;
        @(posedge clk); #1;
        bus_if.start = 1'b0; bus_if.dbus_select = 1'b0;
        check_eq("x_ctrl_acc", {8'd0, bus_if.acc}, 16'h0033);
        check_eq("x_ctrl_c", {15'd0, bus_if.c}, 16'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
